// File: rtl/l1_cache_pkg.sv
// ---------------------------------------------------------------------------
// l1_cache_pkg
// Shared definitions for the split L1 (2-way I-cache, 4-way D-cache) and its
// single L2 port scheduler.
//   - address split: tag 12 / index 14 / offset 6
//   - sched_state_t: port scheduler FSM states
//   - SRC_I / SRC_D: encoding of the requesting L1 on l2_req_src
// ---------------------------------------------------------------------------
package l1_cache_pkg;

  localparam int TAG_WIDTH    = 12;
  localparam int INDEX_WIDTH  = 14;
  localparam int OFFSET_WIDTH = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_INV   = 3'd4
  } sched_state_t;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

endpackage

// File: rtl/l1_l2_port_scheduler_if.sv
// ---------------------------------------------------------------------------
// l1_l2_port_scheduler_if
// Bundles the L1 request, L2 request/response, evict/invalidate and status
// signals of the L2 port scheduler.
//   master : the scheduler's view (drives readies, L2 request, resp pulses,
//            invalidate, busy)
//   slave  : the environment's view (L1 caches and L2)
// ---------------------------------------------------------------------------
interface l1_l2_port_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  d_req_valid;
  logic                  d_req_ready;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic                  d_req_write;
  logic                  l2_req_valid;
  logic                  l2_req_ready;
  logic [ADDR_WIDTH-1:0] l2_req_addr;
  logic                  l2_req_write;
  logic                  l2_req_src;
  logic                  l2_resp_valid;
  logic                  i_resp_valid;
  logic                  d_resp_valid;
  logic                  l2_evict_valid;
  logic [ADDR_WIDTH-1:0] l2_evict_addr;
  logic                  l2_evict_ready;
  logic                  d_inv_valid;
  logic [ADDR_WIDTH-1:0] d_inv_addr;
  logic                  busy;

  modport master (
    input  i_req_valid, i_req_addr,
    input  d_req_valid, d_req_addr, d_req_write,
    input  l2_req_ready, l2_resp_valid,
    input  l2_evict_valid, l2_evict_addr,
    output i_req_ready, d_req_ready,
    output l2_req_valid, l2_req_addr, l2_req_write, l2_req_src,
    output i_resp_valid, d_resp_valid,
    output l2_evict_ready, d_inv_valid, d_inv_addr, busy
  );

  modport slave (
    output i_req_valid, i_req_addr,
    output d_req_valid, d_req_addr, d_req_write,
    output l2_req_ready, l2_resp_valid,
    output l2_evict_valid, l2_evict_addr,
    input  i_req_ready, d_req_ready,
    input  l2_req_valid, l2_req_addr, l2_req_write, l2_req_src,
    input  i_resp_valid, d_resp_valid,
    input  l2_evict_ready, d_inv_valid, d_inv_addr, busy
  );

endinterface

// File: rtl/l1_l2_port_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// l1_rr_arbiter
// Two-input round-robin arbiter (I side vs D side) for L1 read fills.
//   clk, rst_n     : clock, synchronous active-low reset (pointer -> I)
//   req_i, req_d   : read requests
//   upd_en         : a read grant was actually taken this cycle
//   gnt_i, gnt_d   : one-hot grant (combinational)
// The pointer names the side that wins a tie; after a taken grant it moves
// to the side opposite the winner.
// ---------------------------------------------------------------------------
module l1_rr_arbiter (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic upd_en,
  output logic gnt_i,
  output logic gnt_d
);
  import l1_cache_pkg::*;

  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= SRC_I;
    end else if (upd_en) begin
      ptr <= gnt_i ? SRC_D : SRC_I;
    end
  end

  always_comb begin
    gnt_i = req_i & ((ptr == SRC_I) | ~req_d);
    gnt_d = req_d & ((ptr == SRC_D) | ~req_i);
  end

endmodule

// File: rtl/l1_l2_port_scheduler.sv
// ---------------------------------------------------------------------------
// l1_l2_port_scheduler
// Shares the single L2 request port between the L1 I-cache and D-cache and
// turns L2 evict commands into a one-cycle D-cache invalidate. One L2
// transaction is outstanding at a time.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : l1_l2_port_scheduler_if.master (L1 requests, L2 request and
//                response, evict/invalidate, busy)
// Arbitration in IDLE: evict > D writeback > round-robin(I fill, D fill).
// Optional build macro SCHED_STATS_EN adds saturating grant counters
// stat_i_fill, stat_d_fill, stat_d_wb, stat_evict (CNT_WIDTH bits each).
// ---------------------------------------------------------------------------
module l1_l2_port_scheduler #(
  parameter int ADDR_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 6,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l1_l2_port_scheduler_if.master bus
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  stat_i_fill,
  output logic [CNT_WIDTH-1:0]  stat_d_fill,
  output logic [CNT_WIDTH-1:0]  stat_d_wb,
  output logic [CNT_WIDTH-1:0]  stat_evict
`endif
);
  import l1_cache_pkg::*;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    r = a;
    r[OFFSET_WIDTH-1:0] = '0;
    return r;
  endfunction

  sched_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic                  lat_write;
  logic                  lat_src;

  logic idle_ok, evict_req, wb_req, dfill_req;
  logic grant_evict, grant_wb, grant_rd, grant_i, grant_df;
  logic rr_gnt_i, rr_gnt_d;

  // Grants are gated by rst_n so nothing is handshaken during reset.
  always_comb begin
    idle_ok     = (state == ST_IDLE) & rst_n;
    evict_req   = bus.l2_evict_valid;
    wb_req      = bus.d_req_valid & bus.d_req_write;
    dfill_req   = bus.d_req_valid & ~bus.d_req_write;
    grant_evict = idle_ok & evict_req;
    grant_wb    = idle_ok & ~evict_req & wb_req;
    grant_rd    = idle_ok & ~evict_req & ~wb_req;
    grant_i     = grant_rd & rr_gnt_i;
    grant_df    = grant_rd & rr_gnt_d;
  end

  // Writebacks and evicts never move the read pointer.
  l1_rr_arbiter u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (bus.i_req_valid),
    .req_d  (dfill_req),
    .upd_en (grant_i | grant_df),
    .gnt_i  (rr_gnt_i),
    .gnt_d  (rr_gnt_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_evict) begin
          state_nxt = ST_INV;
        end else if (grant_wb | grant_i | grant_df) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (bus.l2_req_ready)  state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.l2_resp_valid) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      ST_INV:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // An evict reuses lat_addr for the invalidate; src/write keep their values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      lat_src   <= SRC_I;
    end else if (grant_evict) begin
      lat_addr  <= line_align(bus.l2_evict_addr);
    end else if (grant_wb | grant_df) begin
      lat_addr  <= line_align(bus.d_req_addr);
      lat_write <= grant_wb;
      lat_src   <= SRC_D;
    end else if (grant_i) begin
      lat_addr  <= line_align(bus.i_req_addr);
      lat_write <= 1'b0;
      lat_src   <= SRC_I;
    end
  end

  always_comb begin
    bus.i_req_ready    = grant_i;
    bus.d_req_ready    = grant_wb | grant_df;
    bus.l2_evict_ready = grant_evict;
    bus.l2_req_valid   = (state == ST_ISSUE);
    bus.l2_req_addr    = lat_addr;
    bus.l2_req_write   = lat_write;
    bus.l2_req_src     = lat_src;
    bus.i_resp_valid   = (state == ST_RESP) & (lat_src == SRC_I);
    bus.d_resp_valid   = (state == ST_RESP) & (lat_src == SRC_D);
    bus.d_inv_valid    = (state == ST_INV);
    bus.d_inv_addr     = lat_addr;
    bus.busy           = (state != ST_IDLE);
  end

`ifdef SCHED_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_i_fill <= '0;
      stat_d_fill <= '0;
      stat_d_wb   <= '0;
      stat_evict  <= '0;
    end else begin
      if (grant_i)     stat_i_fill <= sat_inc(stat_i_fill);
      if (grant_df)    stat_d_fill <= sat_inc(stat_d_fill);
      if (grant_wb)    stat_d_wb   <= sat_inc(stat_d_wb);
      if (grant_evict) stat_evict  <= sat_inc(stat_evict);
    end
  end
`else
  logic unused_cnt_width;
  assign unused_cnt_width = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_l1_l2_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_l1_l2_port_scheduler
// Directed scenarios with literal expectations, then randomized traffic, all
// checked every cycle against a transaction-level reference model.
// Build with +define+SCHED_STATS_EN to include the statistics counters.
// ---------------------------------------------------------------------------
module tb_l1_l2_port_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_l2_port_scheduler_if #(.ADDR_WIDTH(32)) bus ();

`ifdef SCHED_STATS_EN
  logic [15:0] stat_i_fill, stat_d_fill, stat_d_wb, stat_evict;
`endif

  l1_l2_port_scheduler #(.ADDR_WIDTH(32), .OFFSET_WIDTH(6), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SCHED_STATS_EN
    ,
    .stat_i_fill (stat_i_fill),
    .stat_d_fill (stat_d_fill),
    .stat_d_wb   (stat_d_wb),
    .stat_evict  (stat_evict)
`endif
  );

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  // Reference model: one outstanding transaction record plus a pending
  // invalidate; grants come straight from the priority rules.
  bit          m_txn, m_acc, m_done, m_inv, m_wr, m_src, m_ptr;
  logic [31:0] m_addr, m_inv_addr;
  int          ms_i, ms_d, ms_wb, ms_ev;

  bit          exp_i, exp_d, exp_e, exp_l2v, exp_iresp, exp_dresp, exp_inv, exp_busy;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:6], 6'b0};
  endfunction

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] req);
    errors++;
    if (fail_prints < 40) begin
      fail_prints++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) report(name, {31'b0, act}, {31'b0, req});
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) report(name, act, req);
  endtask

  task automatic model_reset();
    m_txn = 0; m_acc = 0; m_done = 0; m_inv = 0; m_wr = 0; m_src = 0; m_ptr = 0;
    m_addr = '0; m_inv_addr = '0;
    ms_i = 0; ms_d = 0; ms_wb = 0; ms_ev = 0;
  endtask

  task automatic model_expect();
    bit free;
    free = !m_txn && !m_inv;
    exp_i = 0; exp_d = 0; exp_e = 0;
    if (rst_n && free) begin
      if (bus.l2_evict_valid) exp_e = 1;
      else if (bus.d_req_valid && bus.d_req_write) exp_d = 1;
      else if (m_ptr == 1'b0) begin
        if (bus.i_req_valid) exp_i = 1;
        else if (bus.d_req_valid) exp_d = 1;
      end else begin
        if (bus.d_req_valid) exp_d = 1;
        else if (bus.i_req_valid) exp_i = 1;
      end
    end
    exp_busy  = !free;
    exp_l2v   = m_txn && !m_acc;
    exp_iresp = m_txn && m_done && (m_src == 1'b0);
    exp_dresp = m_txn && m_done && (m_src == 1'b1);
    exp_inv   = m_inv;
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
    end else if (!m_txn && !m_inv) begin
      if (exp_e) begin
        m_inv = 1; m_inv_addr = align(bus.l2_evict_addr); ms_ev = sat16(ms_ev);
      end else if (exp_d) begin
        m_txn = 1; m_acc = 0; m_done = 0; m_src = 1;
        m_addr = align(bus.d_req_addr); m_wr = bus.d_req_write;
        if (bus.d_req_write) ms_wb = sat16(ms_wb);
        else begin ms_d = sat16(ms_d); m_ptr = 0; end
      end else if (exp_i) begin
        m_txn = 1; m_acc = 0; m_done = 0; m_src = 0;
        m_addr = align(bus.i_req_addr); m_wr = 0; m_ptr = 1;
        ms_i = sat16(ms_i);
      end
    end else if (m_inv) begin
      m_inv = 0;
    end else if (m_done) begin
      m_txn = 0; m_done = 0;
    end else if (m_acc) begin
      if (bus.l2_resp_valid) m_done = 1;
    end else if (bus.l2_req_ready) begin
      m_acc = 1;
    end
  endtask

  task automatic compare();
    if (!rst_n) return;
    chk1("i_req_ready", bus.i_req_ready, exp_i);
    chk1("d_req_ready", bus.d_req_ready, exp_d);
    chk1("l2_evict_ready", bus.l2_evict_ready, exp_e);
    chk1("l2_req_valid", bus.l2_req_valid, exp_l2v);
    if (exp_l2v) begin
      chk32("l2_req_addr", bus.l2_req_addr, m_addr);
      chk1("l2_req_write", bus.l2_req_write, m_wr);
      chk1("l2_req_src", bus.l2_req_src, m_src);
    end
    chk1("i_resp_valid", bus.i_resp_valid, exp_iresp);
    chk1("d_resp_valid", bus.d_resp_valid, exp_dresp);
    chk1("d_inv_valid", bus.d_inv_valid, exp_inv);
    if (exp_inv) chk32("d_inv_addr", bus.d_inv_addr, m_inv_addr);
    chk1("busy", bus.busy, exp_busy);
`ifdef SCHED_STATS_EN
    chk32("stat_i_fill", {16'h0, stat_i_fill}, 32'(ms_i));
    chk32("stat_d_fill", {16'h0, stat_d_fill}, 32'(ms_d));
    chk32("stat_d_wb",   {16'h0, stat_d_wb},   32'(ms_wb));
    chk32("stat_evict",  {16'h0, stat_evict},  32'(ms_ev));
`endif
  endtask

  // Inputs change #1 after posedge; outputs are sampled at the falling edge.
  task automatic mid();
    #4;
    model_expect();
    compare();
  endtask

  task automatic edge_();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input bit drop);
    bit ai, ad, ae;
    mid();
    ai = exp_i; ad = exp_d; ae = exp_e;
    edge_();
    if (drop) begin
      if (ai) bus.i_req_valid = 1'b0;
      if (ad) bus.d_req_valid = 1'b0;
      if (ae) bus.l2_evict_valid = 1'b0;
    end
  endtask

  string seq;

  initial begin
    model_reset();
    bus.i_req_valid = 0; bus.i_req_addr = '0;
    bus.d_req_valid = 0; bus.d_req_addr = '0; bus.d_req_write = 0;
    bus.l2_req_ready = 0; bus.l2_resp_valid = 0;
    bus.l2_evict_valid = 0; bus.l2_evict_addr = '0;
    rst_n = 0;
    @(posedge clk); #1;
    tick(0); tick(0);
    rst_n = 1;

    // Reset state
    mid();
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_l2v", bus.l2_req_valid, 1'b0);
    chk32("rst_l2_addr", bus.l2_req_addr, 32'h0);
    chk32("rst_inv_addr", bus.d_inv_addr, 32'h0);
    chk1("rst_iresp", bus.i_resp_valid, 1'b0);
    chk1("rst_evict_ready", bus.l2_evict_ready, 1'b0);
    edge_();

    // Single I fill, zero-wait L2
    bus.i_req_valid = 1; bus.i_req_addr = 32'h1234_5678; bus.l2_req_ready = 1;
    mid(); chk1("t1_grant", bus.i_req_ready, 1'b1); edge_();
    bus.i_req_valid = 0;
    mid();
    chk1("t1_l2v", bus.l2_req_valid, 1'b1);
    chk32("t1_addr", bus.l2_req_addr, 32'h1234_5640);
    chk1("t1_src", bus.l2_req_src, 1'b0);
    chk1("t1_write", bus.l2_req_write, 1'b0);
    edge_();
    bus.l2_resp_valid = 1;
    mid(); chk1("t1_no_early_resp", bus.i_resp_valid, 1'b0); edge_();
    bus.l2_resp_valid = 0;
    mid(); chk1("t1_iresp_3cyc", bus.i_resp_valid, 1'b1); chk1("t1_no_dresp", bus.d_resp_valid, 1'b0); edge_();
    mid(); chk1("t1_idle", bus.busy, 1'b0); edge_();

    // Re-reset so the pointer is back at I
    rst_n = 0; tick(0); rst_n = 1;

    // I and D fills together: I, D, I, D
    bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_4000;
    bus.d_req_valid = 1; bus.d_req_addr = 32'h0000_8000; bus.d_req_write = 0;
    bus.l2_req_ready = 1; bus.l2_resp_valid = 1;
    seq = "";
    for (int k = 0; k < 16; k++) begin
      mid();
      if (bus.i_req_ready) seq = {seq, "I"};
      if (bus.d_req_ready) seq = {seq, "D"};
      edge_();
    end
    checks++;
    if (seq != "IDID") begin
      errors++;
      $display("FAIL t2_order actual=%s required=IDID", seq);
    end
    bus.i_req_valid = 0; bus.d_req_valid = 0; bus.l2_resp_valid = 0;
    tick(0);

    // D writeback beats an I fill and leaves the pointer at I
    bus.d_req_valid = 1; bus.d_req_write = 1; bus.d_req_addr = 32'hABC0_0040;
    bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_3000;
    mid(); chk1("t3_wb_grant", bus.d_req_ready, 1'b1); chk1("t3_i_wait", bus.i_req_ready, 1'b0); edge_();
    bus.d_req_valid = 0;
    mid();
    chk1("t3_write", bus.l2_req_write, 1'b1);
    chk32("t3_addr", bus.l2_req_addr, 32'hABC0_0040);
    chk1("t3_src", bus.l2_req_src, 1'b1);
    edge_();
    bus.l2_resp_valid = 1; mid(); edge_(); bus.l2_resp_valid = 0;
    bus.d_req_valid = 1; bus.d_req_write = 0; bus.d_req_addr = 32'h0000_5000;
    mid(); chk1("t3_dresp", bus.d_resp_valid, 1'b1); chk1("t3_no_grant_in_resp", bus.d_req_ready, 1'b0); edge_();
    mid(); chk1("t3_ptr_still_i", bus.i_req_ready, 1'b1); chk1("t3_d_loses", bus.d_req_ready, 1'b0); edge_();
    bus.i_req_valid = 0;
    bus.l2_resp_valid = 1;
    repeat (10) tick(1);
    bus.l2_resp_valid = 0;

    // Evict arriving in WAIT waits for IDLE
    bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_6000;
    tick(1); tick(1);
    bus.l2_evict_valid = 1; bus.l2_evict_addr = 32'h0010_0080;
    for (int k = 0; k < 3; k++) begin
      mid(); chk1("t4_evict_held", bus.l2_evict_ready, 1'b0); edge_();
    end
    bus.l2_resp_valid = 1;
    mid(); chk1("t4_evict_held_w", bus.l2_evict_ready, 1'b0); edge_();
    bus.l2_resp_valid = 0;
    mid(); chk1("t4_fill_done", bus.i_resp_valid, 1'b1); chk1("t4_evict_held_r", bus.l2_evict_ready, 1'b0); edge_();
    mid(); chk1("t4_evict_grant", bus.l2_evict_ready, 1'b1); edge_();
    bus.l2_evict_valid = 0;
    mid(); chk1("t4_inv", bus.d_inv_valid, 1'b1); chk32("t4_inv_addr", bus.d_inv_addr, 32'h0010_0080); edge_();
    mid(); chk1("t4_inv_once", bus.d_inv_valid, 1'b0); chk1("t4_idle", bus.busy, 1'b0); edge_();

    // L2 stalls 5 cycles; stray response in ISSUE ignored
    bus.d_req_valid = 1; bus.d_req_write = 0; bus.d_req_addr = 32'h0000_2ABC;
    bus.l2_req_ready = 0;
    tick(1);
    for (int k = 0; k < 5; k++) begin
      bus.l2_resp_valid = (k == 2);
      mid(); chk1("t5_l2v_hold", bus.l2_req_valid, 1'b1); chk32("t5_addr_hold", bus.l2_req_addr, 32'h0000_2A80); edge_();
    end
    bus.l2_resp_valid = 0; bus.l2_req_ready = 1;
    mid(); chk1("t5_l2v", bus.l2_req_valid, 1'b1); edge_();
    for (int k = 0; k < 2; k++) begin
      mid(); chk1("t5_no_dresp", bus.d_resp_valid, 1'b0); chk1("t5_busy", bus.busy, 1'b1); edge_();
    end
    bus.l2_resp_valid = 1; tick(0); bus.l2_resp_valid = 0;
    mid(); chk1("t5_dresp", bus.d_resp_valid, 1'b1); edge_();
    tick(0);

    // Reset in WAIT discards the transaction
    bus.i_req_valid = 1; bus.i_req_addr = 32'h0000_7000;
    tick(1); tick(1);
    rst_n = 0; bus.l2_resp_valid = 1;
    tick(0);
    rst_n = 1;
    mid(); chk1("t6_busy", bus.busy, 1'b0); chk1("t6_no_iresp", bus.i_resp_valid, 1'b0); edge_();
    bus.l2_resp_valid = 0;
    mid(); chk1("t6_no_iresp2", bus.i_resp_valid, 1'b0); edge_();

    // 3 I fills, 2 writebacks, 1 evict
    bus.l2_req_ready = 1; bus.l2_resp_valid = 1;
    for (int k = 0; k < 3; k++) begin
      bus.i_req_valid = 1; bus.i_req_addr = $urandom;
      repeat (5) tick(1);
    end
    for (int k = 0; k < 2; k++) begin
      bus.d_req_valid = 1; bus.d_req_write = 1; bus.d_req_addr = $urandom;
      repeat (5) tick(1);
    end
    bus.l2_evict_valid = 1; bus.l2_evict_addr = $urandom;
    repeat (3) tick(1);
`ifdef SCHED_STATS_EN
    chk32("st_i_fill", {16'h0, stat_i_fill}, 32'd3);
    chk32("st_d_fill", {16'h0, stat_d_fill}, 32'd0);
    chk32("st_d_wb",   {16'h0, stat_d_wb},   32'd2);
    chk32("st_evict",  {16'h0, stat_evict},  32'd1);
`endif

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      bit ai, ad, ae;
      mid();
      ai = exp_i; ad = exp_d; ae = exp_e;
      edge_();
      if (ai) bus.i_req_valid = 0;
      if (ad) bus.d_req_valid = 0;
      if (ae) bus.l2_evict_valid = 0;
      if (!bus.i_req_valid && $urandom_range(0, 2) == 0) begin
        bus.i_req_valid = 1; bus.i_req_addr = $urandom;
      end
      if (!bus.d_req_valid && $urandom_range(0, 2) == 0) begin
        bus.d_req_valid = 1; bus.d_req_addr = $urandom; bus.d_req_write = 1'($urandom_range(0, 1));
      end
      if (!bus.l2_evict_valid && $urandom_range(0, 7) == 0) begin
        bus.l2_evict_valid = 1; bus.l2_evict_addr = $urandom;
      end
      bus.l2_req_ready  = ($urandom_range(0, 3) != 0);
      bus.l2_resp_valid = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 249) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_l2_port_scheduler.md
Name: l1_l2_port_scheduler

Overview:
- Shares the single L2 request port between the L1 instruction cache (2-way) and the L1 data cache (4-way).
- Requesters are I-cache miss fills, D-cache miss fills and D-cache dirty-line writebacks.
- Also sequences L2-initiated evict commands (inclusivity) into a one-cycle invalidate toward the D-cache.
- One L2 transaction outstanding at a time; sits between the split L1 and the L2 interface.

Parameters:
- ADDR_WIDTH, 32, physical address width (tag 12 / index 14 / offset 6).
- OFFSET_WIDTH, 6, byte-select width; these bits are zeroed on every L2 address.
- CNT_WIDTH, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_req_valid  in  1  I-cache fill request
- i_req_ready  out  1  I request accepted this cycle
- i_req_addr  in  ADDR_WIDTH  I fill address
- d_req_valid  in  1  D-cache request
- d_req_ready  out  1  D request accepted this cycle
- d_req_addr  in  ADDR_WIDTH  D address
- d_req_write  in  1  1 = writeback, 0 = fill
- l2_req_valid  out  1  request to L2
- l2_req_ready  in  1  L2 accepts request
- l2_req_addr  out  ADDR_WIDTH  line-aligned address
- l2_req_write  out  1  1 = writeback
- l2_req_src  out  1  0 = I, 1 = D
- l2_resp_valid  in  1  L2 completion of the outstanding transaction
- i_resp_valid  out  1  one-cycle completion pulse to the I-cache
- d_resp_valid  out  1  one-cycle completion pulse to the D-cache
- l2_evict_valid  in  1  L2 evict command
- l2_evict_addr  in  ADDR_WIDTH  evict address
- l2_evict_ready  out  1  evict accepted
- d_inv_valid  out  1  invalidate pulse to the D-cache
- d_inv_addr  out  ADDR_WIDTH  line-aligned invalidate address
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, FSM = IDLE, round-robin pointer = I, latched address/src/write = 0.
- States: IDLE, ISSUE, WAIT, RESP, INV.
- IDLE arbitration, highest priority first:
  - pending evict;
  - D writeback;
  - round-robin between I fill and D fill.
- Only the winner sees ready = 1, combinationally, in IDLE. Losers hold valid; there is no drop.
- The round-robin pointer flips to the other side after each read grant; a writeback grant does not move it.
- Evict win: l2_evict_ready = 1, latch address, go to INV. INV asserts d_inv_valid for exactly 1 cycle, then returns to IDLE.
- Request grant: latch addr (offset bits forced 0), write and src; go to ISSUE.
- ISSUE: l2_req_valid = 1 with stable addr/write/src until l2_req_ready = 1; then go to WAIT.
- WAIT: on l2_resp_valid go to RESP.
- RESP: pulse i_resp_valid or d_resp_valid according to the latched src for 1 cycle; go to IDLE.
- Minimum latency from grant to completion pulse: 3 cycles with zero-wait L2 (grant, ISSUE, WAIT, RESP).
- A new grant is possible in the cycle after RESP.
- l2_resp_valid outside WAIT is ignored.
- l2_evict_ready = 0 outside IDLE; an evict arriving mid-transaction waits.
- An evict hitting the line being filled is not merged. The D-cache sees its fill complete, then the invalidate.
- Simultaneous i/d read requests with pointer = I: I wins, then D in the next IDLE.
- Reset during any state: return to IDLE next edge, outstanding transaction discarded, no resp pulse emitted.

Optional Feature:
- Macro SCHED_STATS_EN.
- Defined:
  - adds outputs stat_i_fill, stat_d_fill, stat_d_wb and stat_evict, each CNT_WIDTH wide;
  - each counter increments on its grant and saturates at all-ones;
  - counters clear on reset.
- Undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package l1_cache_pkg holds:
  - TAG_WIDTH = 12, INDEX_WIDTH = 14, OFFSET_WIDTH = 6;
  - the state enum;
  - the src encoding (SRC_I = 0, SRC_D = 1).
- One natural sub-module: l1_rr_arbiter, a 2-input round-robin with pointer-update enable.

Test Plan:
- Single I fill at 0x1234_5678, L2 ready and resp immediate -> l2_req_addr = 0x1234_5640, src = 0, write = 0; i_resp_valid 3 cycles after grant.
- I and D fills asserted together for 4 transactions -> grant order I, D, I, D.
- D writeback 0xABC0_0040 concurrent with an I fill (pointer = I) -> writeback granted first with write = 1, then the I fill; pointer still = I.
- Evict 0x0010_0080 while in WAIT -> l2_evict_ready stays 0 until IDLE; then d_inv_valid 1 cycle with addr 0x0010_0080.
- l2_req_ready held low 5 cycles -> l2_req_valid/addr stable throughout; a stray l2_resp_valid in ISSUE is ignored.
- rst_n low in WAIT -> next cycle IDLE, busy = 0, no resp pulse. With SCHED_STATS_EN, after 3 I fills, 2 D writebacks and 1 evict the counters read 3/0/2/1.
